// File: rtl/macc_pkg.sv
// ---------------------------------------------------------------------------
// macc_pkg
// Shared types and constants for the macc_seq operand sequencer.
//   state_t    : sequencer states (IDLE, RUN, DRAIN, CAPT, HOLD)
//   LEN_W      : width of the per-vector pair counter / res_len
//   CNT_W      : width of the sload-skew and drain down-counters
//   drain_cyc(): number of zero-product flush cycles for a given MAC latency
// ---------------------------------------------------------------------------
package macc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        CAPT,
        HOLD
    } state_t;

    localparam int MAC_LAT_DEF = 3;
    localparam int DRAIN_CYC   = MAC_LAT_DEF - 1;

    localparam int LEN_W = 8;
    localparam int CNT_W = 8;

    // The last pair's product needs MAC_LAT-1 further ce-cycles to reach
    // accum_out after the cycle in which it was driven.
    function automatic int drain_cyc(input int mac_lat);
        return mac_lat - 1;
    endfunction

endpackage

// File: rtl/macc_seq_res_reg.sv
// ---------------------------------------------------------------------------
// macc_seq_res_reg
// Result holding register for macc_seq. Loads one dot product on cap and
// presents it on a valid/ready stream until accepted; data is only written
// on cap, so it stays stable while res_valid && !res_ready.
// Optional feature macro: MACC_SEQ_LEN_EN (adds cap_len / res_len).
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   cap             load strobe (one cycle)
//   cap_data        value loaded into res_data
//   cap_len         pair count loaded into res_len (MACC_SEQ_LEN_EN only)
//   res_ready       downstream accept
//   res_valid       result valid
//   res_data        signed result
//   res_len         pair count of the result (MACC_SEQ_LEN_EN only)
// ---------------------------------------------------------------------------
module macc_seq_res_reg
    import macc_pkg::*;
#(
    parameter int SIZEOUT = 20
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cap,
    input  logic signed [SIZEOUT-1:0] cap_data,
`ifdef MACC_SEQ_LEN_EN
    input  logic [LEN_W-1:0]          cap_len,
    output logic [LEN_W-1:0]          res_len,
`endif
    input  logic                      res_ready,
    output logic                      res_valid,
    output logic signed [SIZEOUT-1:0] res_data
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
`ifdef MACC_SEQ_LEN_EN
            res_len   <= '0;
`endif
        end else begin
            if (cap) begin
                res_valid <= 1'b1;
                res_data  <= cap_data;
`ifdef MACC_SEQ_LEN_EN
                res_len   <= cap_len;
`endif
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/macc_seq.sv
// ---------------------------------------------------------------------------
// macc_seq
// Operand-side sequencer for an external signed streaming MAC. Accepts
// operand pairs (with a last flag per vector), drives the MAC ce/sload/a/b
// inputs with the sload pulse aligned SLOAD_SKEW ce-cycles after the first
// pair, flushes the MAC pipeline with zero products, captures accum_out and
// returns one result per vector. One vector is in flight at a time.
// Optional feature macro: MACC_SEQ_LEN_EN
//   adds a per-vector pair counter, the res_len output, and forced vector
//   termination when MAX_LEN pairs arrive without in_last.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     operand pair handshake (ready only in IDLE/RUN)
//   in_a, in_b, in_last   signed operands and end-of-vector flag
//   mac_ce, mac_sload     MAC clock enable and accumulator restart
//   mac_a, mac_b          MAC operands
//   mac_accum             MAC accum_out
//   res_valid/res_ready   result handshake
//   res_data              signed dot product (mac_accum verbatim)
//   res_len               pairs in the vector (MACC_SEQ_LEN_EN only)
// ---------------------------------------------------------------------------
module macc_seq
    import macc_pkg::*;
#(
    parameter int SIZEIN     = 8,
    parameter int SIZEOUT    = 20,
    parameter int MAC_LAT    = 3,
    parameter int SLOAD_SKEW = 1,
    parameter int MAX_LEN    = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [SIZEIN-1:0]  in_a,
    input  logic signed [SIZEIN-1:0]  in_b,
    input  logic                      in_last,
    output logic                      mac_ce,
    output logic                      mac_sload,
    output logic signed [SIZEIN-1:0]  mac_a,
    output logic signed [SIZEIN-1:0]  mac_b,
    input  logic signed [SIZEOUT-1:0] mac_accum,
    output logic                      res_valid,
    input  logic                      res_ready,
`ifdef MACC_SEQ_LEN_EN
    output logic [LEN_W-1:0]          res_len,
`endif
    output logic signed [SIZEOUT-1:0] res_data
);

    localparam int DRAIN_N = drain_cyc(MAC_LAT);

    // A one-pair vector must still see its sload pulse before CAPT, so the
    // skew may not exceed the number of drain cycles.
    if (MAC_LAT < 1 || SLOAD_SKEW < 0 || SLOAD_SKEW > DRAIN_N ||
        MAX_LEN < 1 || MAX_LEN > (1 << LEN_W) - 1) begin : g_bad_cfg
        $error("macc_seq: unsupported MAC_LAT/SLOAD_SKEW/MAX_LEN combination");
    end

    localparam state_t AFTER_LAST = (DRAIN_N == 0) ? CAPT : DRAIN;

    state_t             state;
    state_t             state_nxt;
    logic               xfer;
    logic               last_eff;
    logic               cap;
    logic               sload_arm;
    logic               sload_hit;
    logic [CNT_W-1:0]   skew_cnt;
    logic [CNT_W-1:0]   drain_cnt;

    assign in_ready  = (state == IDLE) || (state == RUN);
    assign xfer      = in_valid && in_ready;
    assign sload_hit = sload_arm && (skew_cnt == CNT_W'(1));

`ifdef MACC_SEQ_LEN_EN
    logic [LEN_W-1:0] len_cnt;
    logic [LEN_W-1:0] len_nxt;

    // The first pair of a vector always counts as 1, whatever was left over.
    assign len_nxt  = (state == IDLE) ? LEN_W'(1) : len_cnt + LEN_W'(1);
    assign last_eff = in_last || (len_nxt == LEN_W'(MAX_LEN));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_cnt <= '0;
        end else if (xfer) begin
            len_cnt <= len_nxt;
        end
    end
`else
    assign last_eff = in_last;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mac_ce    = 1'b0;
        mac_sload = 1'b0;
        mac_a     = '0;
        mac_b     = '0;
        cap       = 1'b0;
        case (state)
            IDLE: begin
                if (xfer) begin
                    mac_ce    = 1'b1;
                    mac_a     = in_a;
                    mac_b     = in_b;
                    mac_sload = (SLOAD_SKEW == 0);
                    state_nxt = last_eff ? AFTER_LAST : RUN;
                end
            end
            RUN: begin
                if (xfer) begin
                    mac_ce    = 1'b1;
                    mac_a     = in_a;
                    mac_b     = in_b;
                    mac_sload = sload_hit;
                    if (last_eff) begin
                        state_nxt = AFTER_LAST;
                    end
                end
            end
            DRAIN: begin
                // Zero operands push the last real product through the MAC.
                mac_ce    = 1'b1;
                mac_sload = sload_hit;
                if (drain_cnt == CNT_W'(1)) begin
                    state_nxt = CAPT;
                end
            end
            CAPT: begin
                cap       = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // skew_cnt only moves on ce-cycles so input stalls cannot shift the
    // sload pulse relative to the operand stream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            skew_cnt  <= '0;
            sload_arm <= 1'b0;
            drain_cnt <= '0;
        end else begin
            if (state == IDLE && xfer) begin
                skew_cnt  <= CNT_W'(SLOAD_SKEW);
                sload_arm <= (SLOAD_SKEW != 0);
            end else if (mac_ce && sload_arm) begin
                skew_cnt <= skew_cnt - CNT_W'(1);
                if (sload_hit) begin
                    sload_arm <= 1'b0;
                end
            end

            if (state != DRAIN && state_nxt == DRAIN) begin
                drain_cnt <= CNT_W'(DRAIN_N);
            end else if (state == DRAIN) begin
                drain_cnt <= drain_cnt - CNT_W'(1);
            end
        end
    end

    macc_seq_res_reg #(
        .SIZEOUT (SIZEOUT)
    ) u_res_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .cap       (cap),
        .cap_data  (mac_accum),
`ifdef MACC_SEQ_LEN_EN
        .cap_len   (len_cnt),
        .res_len   (res_len),
`endif
        .res_ready (res_ready),
        .res_valid (res_valid),
        .res_data  (res_data)
    );

endmodule

// File: tb/tb_macc_seq.sv
// ---------------------------------------------------------------------------
// tb_macc_seq
// Bench for macc_seq. Contains a stand-in for the external MAC (registered
// operands, registered product, sload-delayed accumulator restart, 3
// ce-cycles of latency) and a dot-product reference model that sums a*b per
// vector and wraps to SIZEOUT bits.
// ---------------------------------------------------------------------------
module tb_macc_seq;

    localparam int SIZEIN     = 8;
    localparam int SIZEOUT    = 20;
    localparam int MAC_LAT    = 3;
    localparam int SLOAD_SKEW = 1;
`ifdef MACC_SEQ_LEN_EN
    localparam int MAX_LEN    = 4;
    localparam bit LEN_EN     = 1'b1;
`else
    localparam int MAX_LEN    = 255;
    localparam bit LEN_EN     = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      in_valid;
    logic                      in_ready;
    logic signed [SIZEIN-1:0]  in_a;
    logic signed [SIZEIN-1:0]  in_b;
    logic                      in_last;
    logic                      mac_ce;
    logic                      mac_sload;
    logic signed [SIZEIN-1:0]  mac_a;
    logic signed [SIZEIN-1:0]  mac_b;
    logic signed [SIZEOUT-1:0] mac_accum;
    logic                      res_valid;
    logic                      res_ready;
    logic signed [SIZEOUT-1:0] res_data;
`ifdef MACC_SEQ_LEN_EN
    logic [7:0]                res_len;
`endif

    always #5 clk = ~clk;

    macc_seq #(
        .SIZEIN     (SIZEIN),
        .SIZEOUT    (SIZEOUT),
        .MAC_LAT    (MAC_LAT),
        .SLOAD_SKEW (SLOAD_SKEW),
        .MAX_LEN    (MAX_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .mac_ce    (mac_ce),
        .mac_sload (mac_sload),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_accum (mac_accum),
        .res_valid (res_valid),
        .res_ready (res_ready),
`ifdef MACC_SEQ_LEN_EN
        .res_len   (res_len),
`endif
        .res_data  (res_data)
    );

    // External MAC stand-in; it is never cleared by the sequencer's reset.
    logic signed [SIZEIN-1:0]    m_ar = '0;
    logic signed [SIZEIN-1:0]    m_br = '0;
    logic signed [2*SIZEIN-1:0]  m_mult = '0;
    logic                        m_sload_r = 1'b0;
    logic signed [SIZEOUT-1:0]   m_acc_r = '0;

    always @(posedge clk) begin
        if (mac_ce) begin
            m_ar      <= mac_a;
            m_br      <= mac_b;
            m_mult    <= m_ar * m_br;
            m_sload_r <= mac_sload;
            m_acc_r   <= (m_sload_r ? SIZEOUT'(0) : m_acc_r) + SIZEOUT'(m_mult);
        end
    end
    assign mac_accum = m_acc_r;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    bit     rnd_mode = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        longint d;
        int     l;
    } exp_t;

    exp_t   sbq[$];
    longint ref_acc = 0;
    int     ref_cnt = 0;
    longint last_edge = 0;
    bit     vec_open = 1'b0;
    int     ce_idx = 0;
    int     sload_cnt = 0;
    int     sload_pos = -1;
    int     noce_sload = 0;
    bit     prev_rv = 1'b0;
    bit     prev_rr = 1'b0;
    longint prev_rd = 0;

    bit     s_ir, s_rv, s_ce, s_sload, s_xfer;
    longint s_rd;
    int     s_rl;

    // Observes the cycle just before the coming clock edge.
    task automatic mon();
        exp_t e;
        logic signed [SIZEOUT-1:0] w;
        s_ir    = in_ready;
        s_rv    = res_valid;
        s_ce    = mac_ce;
        s_sload = mac_sload;
        s_rd    = longint'(res_data);
`ifdef MACC_SEQ_LEN_EN
        s_rl    = int'(res_len);
`else
        s_rl    = 0;
`endif
        s_xfer  = rst_n && in_valid && in_ready;
        if (!rst_n) begin
            ref_acc  = 0;
            ref_cnt  = 0;
            vec_open = 1'b0;
            prev_rv  = 1'b0;
            prev_rr  = 1'b0;
        end else begin
            if (prev_rv && !prev_rr) begin
                chk("hold_valid", res_valid, 1);
                chk("hold_data", longint'(res_data), prev_rd);
            end
            if (mac_sload && !mac_ce) noce_sload++;
            if (mac_ce) begin
                if (s_xfer && !vec_open) begin
                    vec_open  = 1'b1;
                    ce_idx    = 0;
                    sload_cnt = 0;
                    sload_pos = -1;
                end
                if (mac_sload) begin
                    sload_cnt++;
                    sload_pos = ce_idx;
                end
                ce_idx++;
            end
            if (s_xfer) begin
                ref_acc += longint'(in_a) * longint'(in_b);
                ref_cnt++;
                if (in_last || (LEN_EN && ref_cnt == MAX_LEN)) begin
                    w   = ref_acc[SIZEOUT-1:0];
                    e.d = longint'(w);
                    e.l = ref_cnt;
                    sbq.push_back(e);
                    ref_acc   = 0;
                    ref_cnt   = 0;
                    last_edge = cyc + 1;
                end
            end
            if (res_valid && !prev_rv) chk("latency", cyc - last_edge, MAC_LAT);
            if (res_valid && res_ready) begin
                chk("sb_depth", sbq.size(), 1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("res_data", longint'(res_data), e.d);
`ifdef MACC_SEQ_LEN_EN
                    chk("res_len", s_rl, e.l);
`endif
                end
                chk("sload_count", sload_cnt, 1);
                chk("sload_pos", sload_pos, SLOAD_SKEW);
                vec_open = 1'b0;
            end
            prev_rv = res_valid;
            prev_rr = res_ready;
            prev_rd = longint'(res_data);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
        cyc++;
        if (rnd_mode) res_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_pair(input int a, input int b, input bit last);
        int t;
        t        = 0;
        in_valid = 1'b1;
        in_a     = SIZEIN'(a);
        in_b     = SIZEIN'(b);
        in_last  = last;
        do begin
            tick();
            t++;
        end while (!s_xfer && t < 60);
        chk("xfer_timeout", s_xfer, 1);
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_last  = 1'b0;
    endtask

    task automatic wait_res(output longint d, output int l);
        int t;
        t = 0;
        do begin
            tick();
            t++;
        end while (!s_rv && t < 100);
        chk("res_timeout", s_rv, 1);
        d = s_rd;
        l = s_rl;
    endtask

    typedef struct {
        int n;
        int a [4];
        int b [4];
        int exp_d;
        int exp_l;
    } vec_t;

    vec_t tv [5];

    initial begin
        longint d;
        int     l;
        int     n;

        tv[0] = '{3, '{3, -2, 7, 0},       '{4, 5, 7, 0},      51,     3};
        tv[1] = '{1, '{-128, 0, 0, 0},     '{-128, 0, 0, 0},   16384,  1};
        tv[2] = '{2, '{127, -128, 0, 0},   '{127, -128, 0, 0}, 32513,  2};
        tv[3] = '{1, '{5, 0, 0, 0},        '{-3, 0, 0, 0},     -15,    1};
        tv[4] = '{3, '{-128, -1, 0, 0},    '{127, -1, 9, 0},   -16255, 3};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        res_ready = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", s_ir, 1);
        chk("rst_res_valid", s_rv, 0);
        chk("rst_mac_ce", s_ce, 0);
        chk("rst_mac_sload", s_sload, 0);
        chk("rst_res_data", s_rd, 0);

        // Table-driven vectors.
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < tv[k].n; i++) send_pair(tv[k].a[i], tv[k].b[i], i == tv[k].n - 1);
            wait_res(d, l);
            chk("tbl_data", d, tv[k].exp_d);
`ifdef MACC_SEQ_LEN_EN
            chk("tbl_len", l, tv[k].exp_l);
`endif
        end

        // Input stalls between pairs 1 and 2.
        send_pair(1, 1, 1'b0);
        for (int g = 0; g < 3; g++) begin
            tick();
            chk("gap_ce", s_ce, 0);
            chk("gap_sload", s_sload, 0);
        end
        send_pair(2, 2, 1'b0);
        send_pair(3, 3, 1'b1);
        wait_res(d, l);
        chk("gap_data", d, 14);

        // Result back-pressure.
        res_ready = 1'b0;
        send_pair(3, 4, 1'b0);
        send_pair(-2, 5, 1'b0);
        send_pair(7, 7, 1'b1);
        n = 0;
        do begin
            tick();
            n++;
        end while (!s_rv && n < 100);
        chk("bp_valid_rise", s_rv, 1);
        for (int h = 0; h < 5; h++) begin
            tick();
            chk("bp_valid", s_rv, 1);
            chk("bp_data", s_rd, 51);
            chk("bp_in_ready", s_ir, 0);
        end
        res_ready = 1'b1;
        tick();
        chk("bp_accept_in_ready", s_ir, 0);
        in_valid = 1'b1;
        in_a     = 8'sd10;
        in_b     = 8'sd10;
        in_last  = 1'b1;
        tick();
        chk("bp_next_accept", s_xfer, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_res(d, l);
        chk("bp_next_data", d, 100);

        // Reset in the middle of a vector.
        send_pair(1, 2, 1'b0);
        send_pair(3, 4, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("midrst_in_ready", s_ir, 1);
        chk("midrst_res_valid", s_rv, 0);
        send_pair(10, 10, 1'b1);
        wait_res(d, l);
        chk("midrst_data", d, 100);

`ifdef MACC_SEQ_LEN_EN
        // Forced termination at MAX_LEN.
        for (int i = 0; i < 4; i++) send_pair(1, 1, 1'b0);
        wait_res(d, l);
        chk("force_data", d, 4);
        chk("force_len", l, 4);
`else
        // Accumulator wrap: 40 * 16384 = 655360 wraps to -393216 in 20 bits.
        for (int i = 0; i < 40; i++) send_pair(-128, -128, i == 39);
        wait_res(d, l);
        chk("wrap_data", d, -393216);
`endif

        // Randomized vectors with input gaps and random res_ready.
        rnd_mode = 1'b1;
        for (int v = 0; v < 30; v++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                send_pair(int'($signed(8'($urandom))), int'($signed(8'($urandom))), i == n - 1);
            end
        end
        n = 0;
        while ((sbq.size() != 0 || res_valid) && n < 400) begin
            tick();
            n++;
        end
        rnd_mode  = 1'b0;
        res_ready = 1'b1;
        chk("rnd_drain", sbq.size(), 0);
        repeat (2) tick();
        chk("sload_without_ce", noce_sload, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/macc_seq.md
Name: macc_seq

Overview:
- Operand-side sequencer for the signed streaming multiply-accumulate block.
- Accepts dot-product operand pairs on a valid/ready stream, with a last flag marking the end of each vector.
- Drives the MAC's ce/sload/a/b inputs with correct sload alignment, drains the MAC pipeline, captures accum_out and returns one signed result per vector on a valid/ready stream.
- One vector in flight at a time.

Parameters:
- SIZEIN, 8, operand width (signed)
- SIZEOUT, 20, accumulator/result width (signed)
- MAC_LAT, 3, ce-cycles from a pair being driven to its product appearing in MAC accum_out
- SLOAD_SKEW, 1, ce-cycles between the first pair of a vector and the mac_sload pulse
- MAX_LEN, 255, maximum pairs per vector; only used by the optional feature

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operand pair valid
- in_ready  out  1  high only in IDLE/RUN states
- in_a  in  SIZEIN  signed operand a
- in_b  in  SIZEIN  signed operand b
- in_last  in  1  final pair of the vector
- mac_ce  out  1  MAC clock enable
- mac_sload  out  1  MAC accumulator restart
- mac_a  out  SIZEIN  MAC operand a
- mac_b  out  SIZEIN  MAC operand b
- mac_accum  in  SIZEOUT  MAC accum_out
- res_valid  out  1  result valid
- res_ready  in  1  result accepted
- res_data  out  SIZEOUT  signed dot product
- res_len  out  8  pairs in vector; present only with MACC_SEQ_LEN_EN

Behaviour:
- Reset, rst_n low at a clk edge:
  - state=IDLE; all outputs 0, except in_ready=1.
  - Reset mid-vector discards the vector; no result is produced.
  - The MAC's internal state is not cleared by this block. The next vector's sload restarts the MAC correctly regardless.
- Handshake:
  - A pair transfers when in_valid&in_ready at a clk edge.
  - A result transfers when res_valid&res_ready.
  - res_data and res_len are stable while res_valid=1 && !res_ready.
- mac_a/mac_b/mac_ce are combinational from the input handshake in IDLE/RUN:
  - mac_ce = in_valid&in_ready, mac_a=in_a, mac_b=in_b.
  - When in_valid=0, mac_ce=0 and mac_a/mac_b=0; the MAC is frozen and nothing is lost.
- States:
  - IDLE: on transfer, start a vector. Set skew_cnt=SLOAD_SKEW. Go to DRAIN if in_last, else RUN.
  - RUN: each transfer is one ce-cycle. Go to DRAIN on a transfer with in_last.
  - DRAIN:
    - in_ready=0; mac_ce=1 every cycle, with mac_a=mac_b=0 (zero products).
    - Run MAC_LAT-1 cycles, counted by drain_cnt.
    - After the final drain edge, go to CAPT.
  - CAPT: one cycle. Register mac_accum into res_data, set res_valid=1, go to HOLD.
  - HOLD: wait for res_ready, then res_valid=0 and go to IDLE. A result accepted in HOLD does not overlap the next vector's first pair; the earliest next in_ready is the following cycle.
- sload alignment:
  - mac_sload=1 on exactly one ce-cycle per vector: the ce-cycle SLOAD_SKEW ce-cycles after the first pair's ce-cycle.
  - skew_cnt decrements on each ce-cycle only, so stalls do not shift alignment.
  - This cycle may fall in DRAIN, e.g. for a 1-pair vector; it still fires there.
  - mac_sload=0 whenever mac_ce=0.
- Result latency:
  - res_valid rises MAC_LAT+1 cycles after the last-pair transfer edge, with no stalls.
  - With defaults, last pair at edge t gives res_valid high in the cycle after edge t+3.
- Arithmetic is owned by the MAC. res_data is mac_accum verbatim (signed, SIZEOUT bits, two's-complement wrap on overflow).
- An empty vector is impossible: a vector is at least 1 pair, because in_last travels with a pair.

Optional Feature:
- Macro: MACC_SEQ_LEN_EN.
- With it defined:
  - An 8-bit pair counter counts transfers per vector; res_len = counter value at CAPT.
  - If the counter reaches MAX_LEN without in_last, that transfer is treated as last (forced DRAIN).
- Without it: no counter, no res_len port, and in_last is the only terminator.

Decomposition:
- Package macc_pkg:
  - state enum {IDLE, RUN, DRAIN, CAPT, HOLD}
  - localparam DRAIN_CYC = MAC_LAT-1
  - counter width constants
- Natural sub-module: macc_seq_res_reg, the result register plus its valid/ready hold logic.
- The MAC itself is instantiated by the parent, not inside this block.

Test Plan:
- Vector (3,4),(-2,5),(7,7,last) with defaults and res_ready=1 -> exactly one mac_sload, on the 2nd ce-cycle; res_data=51, res_valid 4 cycles after the last transfer.
- Single pair (-128,-128,last) -> sload fires during DRAIN; res_data=16384; with MACC_SEQ_LEN_EN, res_len=1.
- in_valid deasserted 3 cycles between pairs 1 and 2 of (1,1),(2,2),(3,3,last) -> mac_ce=0 and mac_sload=0 during the gaps; sload still on the 2nd ce-cycle; res_data=14.
- res_ready held low 5 cycles -> res_valid and res_data=51 stable, in_ready=0 throughout; next vector accepted the cycle after acceptance.
- rst_n low for 1 cycle during RUN, then vector (10,10,last) -> no stale result; res_data=100.
- MACC_SEQ_LEN_EN, MAX_LEN=4: 4 pairs of (1,1) with no last -> forced termination; res_data=4, res_len=4.
